// File: rtl/smvm_stream.sv
`timescale 1ns/1ps
// Streaming sparse-matrix x dense-vector engine: header, vector, then row-major nonzeros with
// end-of-row flags; row sums go to an output FIFO. Define SMVM_SAT_EN for saturating accumulation.
module smvm_stream #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned MAX_COLS  = 128,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_val_i,
    input  logic [IDX_W-1:0]  in_col_i,
    input  logic              in_eor_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  out_data_o,
    output logic [IDX_W-1:0]  out_row_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned ProdW = 2 * DATA_W;
    localparam int unsigned VIdxW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int unsigned PtrW  = $clog2(OUT_DEPTH);
    localparam int unsigned CntW  = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StVecIn, StMatIn, StDrain} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   rows_q, rows_d;
    logic [IDX_W-1:0]    cols_q, cols_d;
    logic [IDX_W-1:0]    vec_cnt_q, vec_cnt_d;
    logic [DATA_W-1:0]   row_cnt_q, row_cnt_d;

    logic signed [DATA_W-1:0] vec_q [MAX_COLS];

    logic                s1_valid_q, s1_eor_q, s1_last_q;
    logic signed [ProdW-1:0] s1_prod_q;
    logic [IDX_W-1:0]    s1_row_q;

    logic signed [ACC_W-1:0] acc_q;
    logic                s2_valid_q, s2_last_q;
    logic [ACC_W-1:0]    s2_data_q;
    logic [IDX_W-1:0]    s2_row_q;

    logic [ACC_W-1:0]    fifo_data_q [OUT_DEPTH];
    logic [IDX_W-1:0]    fifo_row_q [OUT_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     fifo_cnt_q;

    logic                err_q, done_q;

    logic                ready_int, accept, room;
    logic                hdr_err, vec_we, mat_acc, col_ok;
    logic [VIdxW-1:0]    rd_idx;
    logic signed [DATA_W-1:0] vec_rd;
    logic signed [ProdW-1:0]  prod;
    logic signed [ACC_W-1:0]  prod_ext, sum;
    logic                push, pop;

    // In-flight eor beats plus queued results must never exceed the FIFO depth.
    assign room = (32'(fifo_cnt_q) + 32'(s1_eor_q) + 32'(s2_valid_q)) < OUT_DEPTH;

    always_comb begin
        ready_int = 1'b0;
        case (state_q)
            StIdle, StVecIn: ready_int = 1'b1;
            StMatIn:         ready_int = room;
            default:         ready_int = 1'b0;
        endcase
    end

    assign in_ready_o = ready_int & ~rst;
    assign accept     = in_valid_i & in_ready_o;
    assign col_ok     = in_col_i < cols_q;

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        vec_cnt_d = vec_cnt_q;
        row_cnt_d = row_cnt_q;
        hdr_err   = 1'b0;
        vec_we    = 1'b0;
        mat_acc   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (32'(in_col_i) > MAX_COLS) begin
                        hdr_err = 1'b1;
                    end else if (in_val_i != '0 && in_col_i != '0) begin
                        rows_d    = in_val_i;
                        cols_d    = in_col_i;
                        vec_cnt_d = '0;
                        row_cnt_d = '0;
                        state_d   = StVecIn;
                    end
                end
            end
            StVecIn: begin
                if (accept) begin
                    vec_we    = 1'b1;
                    vec_cnt_d = vec_cnt_q + IDX_W'(1);
                    if (vec_cnt_q == cols_q - IDX_W'(1)) begin
                        state_d = StMatIn;
                    end
                end
            end
            StMatIn: begin
                if (accept) begin
                    mat_acc = 1'b1;
                    if (in_eor_i) begin
                        row_cnt_d = row_cnt_q + DATA_W'(1);
                        if (row_cnt_q == rows_q - DATA_W'(1)) begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rows_q    <= '0;
            cols_q    <= '0;
            vec_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            vec_cnt_q <= vec_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Vector store is deliberately never cleared; only entries below cols are ever read.
    always_ff @(posedge clk) begin
        if (vec_we) begin
            vec_q[vec_cnt_q[VIdxW-1:0]] <= $signed(in_val_i);
        end
    end

    assign rd_idx = col_ok ? in_col_i[VIdxW-1:0] : '0;
    assign vec_rd = vec_q[rd_idx];
    assign prod   = col_ok ? ProdW'($signed(in_val_i)) * ProdW'(vec_rd) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_eor_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
            s1_row_q   <= '0;
        end else begin
            s1_valid_q <= mat_acc;
            s1_eor_q   <= mat_acc & in_eor_i;
            s1_last_q  <= row_cnt_q == rows_q - DATA_W'(1);
            s1_prod_q  <= prod;
            s1_row_q   <= IDX_W'(row_cnt_q);
        end
    end

    assign prod_ext = ACC_W'(s1_prod_q);

`ifdef SMVM_SAT_EN
    localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  sat_q, sat_hit;

    // Once a row clamps it stays clamped until its eor.
    always_comb begin
        sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
        sat_hit  = sat_q;
        sum      = sum_wide[ACC_W-1:0];
        if (sat_q) begin
            sum = acc_q;
        end else if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum     = sum_wide[ACC_W] ? AccMin : AccMax;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (s1_valid_q) begin
            sat_q <= s1_eor_q ? 1'b0 : sat_hit;
        end
    end
`else
    assign sum = acc_q + prod_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= '0;
            s2_row_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q & s1_eor_q;
            if (s1_valid_q) begin
                if (s1_eor_q) begin
                    acc_q     <= '0;
                    s2_data_q <= sum;
                    s2_row_q  <= s1_row_q;
                    s2_last_q <= s1_last_q;
                end else begin
                    acc_q <= sum;
                end
            end
        end
    end

    assign push = s2_valid_q;
    assign pop  = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= s2_data_q;
            fifo_row_q[wr_ptr_q]  <= s2_row_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            err_q  <= hdr_err | (mat_acc & ~col_ok);
            done_q <= s2_valid_q & s2_last_q;
        end
    end

    assign out_valid_o = fifo_cnt_q != '0;
    assign out_data_o  = out_valid_o ? fifo_data_q[rd_ptr_q] : '0;
    assign out_row_o   = out_valid_o ? fifo_row_q[rd_ptr_q] : '0;
    assign busy_o      = (state_q != StIdle) | s1_valid_q | s2_valid_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_smvm_stream.sv
`timescale 1ns/1ps
// Scoreboard bench for smvm_stream: expected row sums come from a plain-arithmetic model and are
// queued at issue time; a monitor pops and compares on every output handshake.
module tb_smvm_stream;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int MC = 128;
    localparam int AW = 16;
    localparam int OD = 4;
    localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (AW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_val = '0;
    logic [IW-1:0] in_col = '0;
    logic          in_eor = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_data;
    logic [IW-1:0] out_row;
    logic          busy, done, err;

    smvm_stream #(
        .DATA_W   (DW),
        .IDX_W    (IW),
        .MAX_COLS (MC),
        .ACC_W    (AW),
        .OUT_DEPTH(OD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_val_i   (in_val),
        .in_col_i   (in_col),
        .in_eor_i   (in_eor),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_row_o  (out_row),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     row;
        longint data;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   err_cnt = 0;
    int   done_cnt = 0;
    int   out_cnt = 0;
    int   vec_m[MC];
    bit   rand_bp = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint wrap(input longint x);
        longint m;
        m = x & ((64'sd1 <<< AW) - 1);
        if (m > AMAX) m -= (64'sd1 <<< AW);
        return m;
    endfunction

    // Monitor: counts pulses and checks every accepted result against the scoreboard.
    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            if (err) err_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got row %0d data %0d, required none",
                             out_row, $signed(out_data));
                end else begin
                    e = exp_q.pop_front();
                    check("out_row", longint'(out_row), longint'(e.row));
                    check("out_data", longint'($signed(out_data)), e.data);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end just after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int val, input int col, input bit eor);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_val   = DW'(val);
        in_col   = IW'(col);
        in_eor   = eor;
        @(negedge clk);
        while (!in_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) check("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            tick(1);
            w++;
        end
        if (w >= 500) check("drain_timeout", exp_q.size(), 0);
        tick(2);
    endtask

    task automatic run_problem(input int rows, input int cols);
        int     e0, d0, exp_err, nnz, v, c;
        longint acc, term;
        bit     sat;
        e0 = err_cnt;
        d0 = done_cnt;
        exp_err = 0;
        drive_beat(rows, cols, 1'b0);
        for (int k = 0; k < cols; k++) begin
            v = int'($urandom_range(0, 255)) - 128;
            vec_m[k] = v;
            drive_beat(v, int'($urandom_range(0, 255)), 1'b0);
        end
        for (int r = 0; r < rows; r++) begin
            nnz = int'($urandom_range(0, 3));
            acc = 0;
            sat = 1'b0;
            if (nnz == 0) begin
                exp_q.push_back('{row: r, data: 0});
                drive_beat(0, 0, 1'b1);
            end else begin
                for (int j = 0; j < nnz; j++) begin
                    v = int'($urandom_range(0, 255)) - 128;
                    if ($urandom_range(0, 7) == 0) c = int'($urandom_range(cols, 255));
                    else c = int'($urandom_range(0, cols - 1));
                    if (c >= cols) begin
                        exp_err++;
                        term = 0;
                    end else begin
                        term = longint'(v) * longint'(vec_m[c]);
                    end
`ifdef SMVM_SAT_EN
                    if (!sat) begin
                        acc += term;
                        if (acc > AMAX) begin
                            acc = AMAX;
                            sat = 1'b1;
                        end else if (acc < AMIN) begin
                            acc = AMIN;
                            sat = 1'b1;
                        end
                    end
`else
                    acc = wrap(acc + term);
`endif
                    if (j == nnz - 1) exp_q.push_back('{row: r, data: acc});
                    drive_beat(v, c, j == nnz - 1);
                end
            end
        end
        wait_idle();
        check("rand_done_count", done_cnt - d0, 1);
        check("rand_err_count", err_cnt - e0, exp_err);
    endtask

    initial begin
        int e0, d0, o0;
        longint sat_exp;
        // Reset values.
        tick(1);
        @(negedge clk);
        check("ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        check("out_valid_reset", out_valid, 0);
        check("out_data_reset", out_data, 0);
        check("out_row_reset", out_row, 0);
        check("busy_reset", busy, 0);
        check("done_reset", done, 0);
        check("err_reset", err, 0);
        @(posedge clk);
        #1;

        // Basic 2x3 problem.
        e0 = err_cnt;
        d0 = done_cnt;
        exp_q.push_back('{row: 0, data: 6});
        exp_q.push_back('{row: 1, data: -21});
        drive_beat(2, 3, 1'b0);
        drive_beat(2, 0, 1'b0);
        drive_beat(-3, 0, 1'b0);
        drive_beat(4, 0, 1'b0);
        drive_beat(5, 0, 1'b0);
        drive_beat(-1, 2, 1'b1);
        drive_beat(7, 1, 1'b1);
        wait_idle();
        check("basic_done_count", done_cnt - d0, 1);
        check("basic_err_count", err_cnt - e0, 0);
        check("basic_busy", busy, 0);
        check("basic_ready_idle", in_ready, 1);

        // Latency: eor accepted at edge t gives out_valid after edge t+2.
        out_ready = 1'b0;
        exp_q.push_back('{row: 0, data: 15});
        drive_beat(1, 1, 1'b0);
        drive_beat(5, 0, 1'b0);
        drive_beat(3, 0, 1'b1);
        @(negedge clk);
        check("lat_valid_t0", out_valid, 0);
        @(negedge clk);
        check("lat_valid_t1", out_valid, 0);
        @(negedge clk);
        check("lat_valid_t2", out_valid, 1);
        check("lat_data_t2", longint'($signed(out_data)), 15);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();

        // Empty row and bad column.
        e0 = err_cnt;
        exp_q.push_back('{row: 0, data: 0});
        exp_q.push_back('{row: 1, data: 0});
        drive_beat(2, 3, 1'b0);
        drive_beat(1, 0, 1'b0);
        drive_beat(2, 0, 1'b0);
        drive_beat(3, 0, 1'b0);
        drive_beat(0, 0, 1'b1);
        drive_beat(9, 5, 1'b1);
        wait_idle();
        check("badcol_err_count", err_cnt - e0, 1);

        // Backpressure: six single-nonzero rows with the output stalled.
        d0 = done_cnt;
        o0 = out_cnt;
        out_ready = 1'b0;
        drive_beat(6, 2, 1'b0);
        drive_beat(3, 0, 1'b0);
        drive_beat(-4, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{row: i, data: (i + 1) * ((i % 2 == 0) ? 3 : -4)});
        end
        for (int i = 0; i < 4; i++) drive_beat(i + 1, i % 2, 1'b1);
        in_valid = 1'b1;
        in_val   = DW'(5);
        in_col   = IW'(0);
        in_eor   = 1'b1;
        @(negedge clk);
        check("bp_ready_after_4th", in_ready, 0);
        repeat (3) @(negedge clk);
        check("bp_ready_held", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_beat(5, 0, 1'b1);
        drive_beat(6, 1, 1'b1);
        wait_idle();
        check("bp_out_count", out_cnt - o0, 6);
        check("bp_done_count", done_cnt - d0, 1);

        // Saturation / wrap on three 127*127 products.
`ifdef SMVM_SAT_EN
        sat_exp = 32767;
`else
        sat_exp = -17149;
`endif
        exp_q.push_back('{row: 0, data: sat_exp});
        drive_beat(1, 1, 1'b0);
        drive_beat(127, 0, 1'b0);
        drive_beat(127, 0, 1'b0);
        drive_beat(127, 0, 1'b0);
        drive_beat(127, 0, 1'b1);
        wait_idle();

        // Header bounds.
        e0 = err_cnt;
        drive_beat(1, 200, 1'b0);
        tick(2);
        check("hdr_cols_err", err_cnt - e0, 1);
        check("hdr_cols_busy", busy, 0);
        drive_beat(0, 3, 1'b0);
        tick(2);
        check("hdr_rows0_err", err_cnt - e0, 1);
        check("hdr_rows0_busy", busy, 0);
        check("hdr_rows0_ready", in_ready, 1);

        // Randomized problems under random output backpressure.
        rand_bp = 1'b1;
        for (int p = 0; p < 14; p++) begin
            run_problem(int'($urandom_range(1, 6)), int'($urandom_range(1, 9)));
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        tick(1);

        // Reset in the middle of MAT_IN with two results queued.
        out_ready = 1'b0;
        drive_beat(4, 1, 1'b0);
        drive_beat(2, 0, 1'b0);
        exp_q.push_back('{row: 0, data: 2});
        exp_q.push_back('{row: 1, data: 4});
        drive_beat(1, 0, 1'b1);
        drive_beat(2, 0, 1'b1);
        tick(3);
        drive_beat(3, 0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        d0 = done_cnt;
        exp_q.push_back('{row: 0, data: -42});
        drive_beat(1, 1, 1'b0);
        drive_beat(-7, 0, 1'b0);
        drive_beat(6, 0, 1'b1);
        wait_idle();
        check("post_rst_done", done_cnt - d0, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
